// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-port ALU sequencer: datapath widths and
// the FSM state encoding used by alu_share_ctrl.
package alu_share_ctrl_pkg;

  localparam int ALU_W = 8;
  localparam int OP_W  = 4;
  localparam int ID_W  = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_EXEC = S_EXEC,
    ST_RESP = S_RESP
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: valid[1:0] (requests), last_id (previous winner), enable (grant
// allowed this cycle), grant[1:0] (one-hot), id (encoded winner).
// On a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_id,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       id
);

  assign grant[0] = enable & valid[0] & (~valid[1] |  last_id);
  assign grant[1] = enable & valid[1] & (~valid[0] | ~last_id);
  assign id       = grant[1];

endmodule

// File: rtl/top_alu.sv
// Shared combinational 8-bit ALU.
// Ports: a, b (operands), op (4-bit opcode), out (result).
// Shift and rotate opcodes use b[2:0] as the shift amount.
module top_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] out
);

  logic [2:0]  w_sh;
  logic [15:0] w_dbl;

  assign w_sh  = b[2:0];
  // Rotate-left: upper byte of the doubled operand shifted left.
  assign w_dbl = {a, a} << w_sh;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    out = '0;
    case (op)
      4'd0:  out = a + b;
      4'd1:  out = a - b;
      4'd2:  out = a & b;
      4'd3:  out = a | b;
      4'd4:  out = a ^ b;
      4'd5:  out = a << w_sh;
      4'd6:  out = a >> w_sh;
      4'd7:  out = $unsigned($signed(a) >>> w_sh);
      4'd8:  out = ~(a & b);
      4'd9:  out = ~(a | b);
      4'd10: out = ~(a ^ b);
      4'd11: out = {7'd0, (a < b)};
      4'd12: out = {7'd0, ($signed(a) < $signed(b))};
      4'd13: out = w_dbl[15:8];
      4'd14: out = a;
      4'd15: out = b;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one top_alu between two requesters. A round-robin winner's operands
// are registered (IDLE), the ALU result is registered (EXEC), and the result
// is offered on a valid/ready response channel tagged with the id (RESP).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready           request handshake per requester
//   reqN_a/b/op                operands and opcode per requester
//   rsp_valid/ready            response handshake
//   rsp_data, rsp_id           registered result and issuing requester
//   busy                       high whenever not IDLE
//   cnt0, cnt1                 completed responses per requester (wrapping)
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_data,
  output logic [ID_W-1:0]  rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ALU_W-1:0] r_a;
  logic [ALU_W-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_last_id;
  logic [ALU_W-1:0] r_result;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic [1:0]       w_valid;
  logic [1:0]       w_grant;
  logic             w_grant_id;
  logic             w_arb_en;
  logic             w_accept;
  logic             w_rsp_fire;
  logic [ALU_W-1:0] w_alu_out;

  assign w_valid  = {req1_valid, req0_valid};
  // Gating with rst_n keeps both readies low while reset is asserted.
  assign w_arb_en = (r_state == ST_IDLE) & rst_n;

  rr_arb2 u_arb (
    .valid   (w_valid),
    .last_id (r_last_id),
    .enable  (w_arb_en),
    .grant   (w_grant),
    .id      (w_grant_id)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_accept   = |w_grant;
  assign w_rsp_fire = (r_state == ST_RESP) & rsp_ready;

  // The ALU only ever sees registered operands, so request inputs have no
  // combinational path to the response.
  top_alu u_alu (
    .a   (r_a),
    .b   (r_b),
    .op  (r_op),
    .out (w_alu_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
      ST_EXEC:                 w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_fire) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: these are plain flops (no memory array), so all of them are reset,
  // which also guarantees the documented reset values on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_id      <= '0;
      r_last_id <= 1'b1;   // requester 0 wins the first tie
      r_result  <= '0;
      r_cnt0    <= '0;
      r_cnt1    <= '0;
    end else begin
      if (w_accept) begin
        r_a       <= w_grant_id ? req1_a  : req0_a;
        r_b       <= w_grant_id ? req1_b  : req0_b;
        r_op      <= w_grant_id ? req1_op : req0_op;
        r_id      <= w_grant_id;
        r_last_id <= w_grant_id;
      end
      if (r_state == ST_EXEC) r_result <= w_alu_out;
      if (w_rsp_fire) begin
        if (r_id == 1'b1) r_cnt1 <= r_cnt1 + CNT_W'(1);
        else              r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_result;
  assign rsp_id    = r_id;
  assign busy      = (r_state != ST_IDLE);
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-port sequencer that shares one `top_alu` instance (8-bit `a`/`b`, 4-bit `op`, combinational 8-bit `out`) between two requesters. It arbitrates round-robin and latches the winner's operands. It runs the ALU for one cycle and returns the registered result over a valid/ready response channel tagged with the requester id. It sits between the two client blocks and the ALU and is the only driver of the ALU inputs.

## Interface
- `CNT_W`, 16: width of each per-requester completed-operation counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1 each  request present.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle when also valid.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  8 each  operands.
- `req0_op`, `req1_op`  in  4 each  ALU opcode, passed unchanged to `top_alu`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_data`  out  8  ALU result.
- `rsp_id`  out  1  requester that issued the result.
- `busy`  out  1  high whenever state is not IDLE.
- `cnt0`, `cnt1`  out  CNT_W each  completed responses per requester.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant logic: if exactly one requester is valid, grant it. If both are valid, grant the one not equal to `last_id`.
  - `reqN_ready = (state==IDLE) & grant_N`.
  - On the accept edge: latch `a`, `b`, `op` and `id`; set `last_id <= id`; go to EXEC.
  - No grant lock: grant is recomputed every cycle, and a requester may drop valid before it is accepted.
- **EXEC**: the ALU sees only the latched operands. Capture `top_alu.out` into the result register and go to RESP.
- **RESP**
  - `rsp_valid=1`; `rsp_data` and `rsp_id` are held stable.
  - On `rsp_valid & rsp_ready`: increment `cnt[rsp_id]` (wraps modulo 2^CNT_W) and go to IDLE.
- Requester inputs are ignored outside the accept cycle. Operand changes after acceptance do not affect the result.
- Reset values:
  - State IDLE; `last_id=1`, so requester 0 wins the first tie.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `busy=0`, `cnt0=cnt1=0`.
  - Both `req_ready` are 0 while `rst_n` is low.
- Reset mid-operation (EXEC or RESP): the transaction is dropped, no response is produced, and counters clear.

## Timing
- Accept at cycle N gives EXEC at N+1 and `rsp_valid` high at N+2. All outputs except `req_ready` come from registers.
- If `rsp_ready` is high at N+2, the FSM is back in IDLE at N+3. The earliest next accept is N+3, so peak throughput is 1 op per 3 cycles.
- Back-pressure: while `rsp_ready` is low, RESP holds indefinitely and both `req_ready` stay 0.
- `req_ready` is combinational from state, `last_id` and the valids. There is no path from operands to ready.
- Requester inputs reach the ALU only through the operand register, so there is no combinational path from request inputs to `rsp_*`.

## Structure
- Shared package:
  - state encoding localparams (`S_IDLE=2'd0`, `S_EXEC=2'd1`, `S_RESP=2'd2`);
  - `ALU_W=8`, `OP_W=4`, `ID_W=1`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `valid[1:0]`, `last_id`, `enable`.
  - Outputs: one-hot `grant[1:0]` and encoded `id`.
  - Purely combinational; `last_id` is held in `alu_share_ctrl`.
- `top_alu` is instantiated unchanged inside `alu_share_ctrl`.

## Test plan
1. Single request: requester 0 presents a=34, b=3, op=0 with `rsp_ready=1`.
   - `req0_ready` is high in the same cycle.
   - `rsp_valid` rises exactly 2 cycles later with `rsp_id=0` and `rsp_data` equal to the golden `top_alu(34,3,0)`.
   - `cnt0=1`.
2. Contention: both requesters hold valid continuously after reset (requester 0 op=1, requester 1 op=2).
   - Accepts alternate 0,1,0,1, spaced exactly 3 cycles apart.
   - Responses carry ids 0,1,0,1.
   - `cnt0=cnt1=2`.
3. Back-pressure: `rsp_ready` held low for 5 cycles in RESP.
   - `rsp_valid`, `rsp_data` and `rsp_id` stay constant.
   - Both `req_ready` stay 0 and no counter changes.
   - The response completes in the cycle `rsp_ready` rises.
4. Operand isolation: requester 1 changes a from 34 to 0 the cycle after acceptance (op=5).
   - The result matches golden `top_alu(34,3,5)`, not `(0,3,5)`.
5. Reset mid-operation: `rst_n` is pulsed low during EXEC.
   - `rsp_valid=0` and `busy=0` immediately, without waiting for a clock edge.
   - Counters read 0.
   - After release, with both requesters valid, requester 0 is granted first.
6. Opcode sweep: requester 1 issues a=34, b=3, op=0..15 with random `rsp_ready` stalls.
   - 16 responses in order, each matching the golden model.
   - `cnt1=16`, `cnt0=0`.
